// File: rtl/tm1638_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_display_ctrl
// Brief    : Autonomous front-end for the tm1638_led_key driver. It
//            initialises the LED&KEY shield, keeps the eight digits and
//            eight LEDs in sync with its inputs, and polls and debounces
//            the keys.
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_display_ctrl #(
    parameter int         CLOCK_FREQ_MHz = 12,
    parameter int         POLL_MS        = 10,
    parameter logic [2:0] BRIGHTNESS     = 3'd7
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_value,
    input  logic [7:0]   i_dp,
    input  logic [7:0]   i_leds,
    input  logic         i_update,
    input  logic         i_lk_idle,
    input  logic [7:0]   i_lk_btn_state,
    output logic         o_cmd_en,
    output logic         o_batch_en,
    output logic         o_btn_en,
    output logic [7:0]   o_data,
    output logic [4:0]   o_batch_data_size,
    output logic [135:0] o_batch_data,
    output logic [27:0]  o_wait_counter,
    output logic [7:0]   o_btn_held,
    output logic [7:0]   o_btn_pressed,
    output logic         o_busy
);

    localparam int          c_poll_cycles = POLL_MS * 1000 * CLOCK_FREQ_MHz;
    localparam int          c_tmr_w       = (c_poll_cycles > 2) ? $clog2(c_poll_cycles) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_poll_cycles - 1);
    localparam logic [7:0]  c_cmd_mode    = 8'h40;
    localparam logic [7:0]  c_cmd_on      = {5'b10001, BRIGHTNESS};

    typedef enum logic [3:0] {
        S_INIT_MODE = 4'd0,
        S_INIT_DATA = 4'd1,
        S_INIT_ON   = 4'd2,
        S_IDLE      = 4'd3,
        S_REF_MODE  = 4'd4,
        S_REF_DATA  = 4'd5,
        S_POLL      = 4'd6,
        S_SAMPLE    = 4'd7,
        S_SKIP      = 4'd8,
        S_WAIT      = 4'd9
    } state_t;

    state_t               r_state, w_state_next;
    state_t               r_ret, w_ret_next;
    logic                 r_run;
    logic                 r_init_phase;
    logic                 r_ref_pending;
    logic                 r_poll_pending;
    logic [c_tmr_w-1:0]   r_timer;
    logic [31:0]          r_snap_value;
    logic [7:0]           r_snap_dp;
    logic [7:0]           r_snap_leds;
    logic [135:0]         r_batch_data;
    logic [7:0]           r_last;
    logic [7:0]           r_held;
    logic [7:0]           r_held_d;
    logic [7:0]           r_pressed;

    logic                 w_go;
    logic                 w_cmd_en;
    logic                 w_batch_en;
    logic                 w_btn_en;
    logic [7:0]           w_cmd_byte;
    logic                 w_diff;
    logic                 w_refresh;
    logic                 w_tmr_tc;
    logic [135:0]         w_payload;

    // Hex nibble to segment pattern (dp bit excluded).
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    // Batch payload built live from the inputs: address byte, then digit/LED pairs.
    assign w_payload[135:128] = 8'hC0;
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign w_payload[127-16*gi -: 8] = {i_dp[7-gi], seg7(i_value[31-4*gi -: 4])};
        assign w_payload[119-16*gi -: 8] = {7'b0000000, i_leds[7-gi]};
    end

    // r_run blocks requests until the first clock after reset release.
    assign w_go      = r_run & i_lk_idle;
    assign w_diff    = (i_value != r_snap_value) | (i_dp != r_snap_dp) | (i_leds != r_snap_leds);
    assign w_refresh = r_ref_pending | w_diff;
    assign w_tmr_tc  = (r_timer == c_tmr_last);

    // Next-state and request decode; every issuing state returns through SKIP/WAIT.
    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        w_cmd_en     = 1'b0;
        w_batch_en   = 1'b0;
        w_btn_en     = 1'b0;
        w_cmd_byte   = 8'h00;
        case (r_state)
            S_INIT_MODE: if (w_go) begin
                w_cmd_en = 1'b1; w_cmd_byte = c_cmd_mode;
                w_ret_next = S_INIT_DATA; w_state_next = S_SKIP;
            end
            S_INIT_DATA: if (w_go) begin
                w_batch_en = 1'b1; w_ret_next = S_INIT_ON; w_state_next = S_SKIP;
            end
            S_INIT_ON: if (w_go) begin
                w_cmd_en = 1'b1; w_cmd_byte = c_cmd_on;
                w_ret_next = S_IDLE; w_state_next = S_SKIP;
            end
            S_IDLE: begin
                if (w_refresh)           w_state_next = S_REF_MODE;
                else if (r_poll_pending) w_state_next = S_POLL;
            end
            S_REF_MODE: if (w_go) begin
                w_cmd_en = 1'b1; w_cmd_byte = c_cmd_mode;
                w_ret_next = S_REF_DATA; w_state_next = S_SKIP;
            end
            S_REF_DATA: if (w_go) begin
                w_batch_en = 1'b1; w_ret_next = S_IDLE; w_state_next = S_SKIP;
            end
            S_POLL: if (w_go) begin
                w_btn_en = 1'b1; w_ret_next = S_SAMPLE; w_state_next = S_SKIP;
            end
            S_SAMPLE: w_state_next = S_IDLE;
            S_SKIP:   w_state_next = S_WAIT;
            S_WAIT:   if (i_lk_idle) w_state_next = r_ret;
            default:  w_state_next = S_INIT_MODE;
        endcase
    end

    // FSM state and return-state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INIT_MODE;
            r_ret   <= S_INIT_MODE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
            r_run   <= 1'b1;
        end
    end

    // Refresh bookkeeping and snapshot of what the last batch carried.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_phase  <= 1'b1;
            r_ref_pending <= 1'b0;
            r_snap_value  <= '0;
            r_snap_dp     <= '0;
            r_snap_leds   <= '0;
            r_batch_data  <= '0;
        end else begin
            if (w_state_next == S_IDLE) r_init_phase <= 1'b0;
            if (w_batch_en) begin
                r_ref_pending <= 1'b0;
                r_snap_value  <= i_value;
                r_snap_dp     <= i_dp;
                r_snap_leds   <= i_leds;
                r_batch_data  <= w_payload;
            end else if (i_update && !r_init_phase) begin
                r_ref_pending <= 1'b1;
            end
        end
    end

    // Free-running poll timer; expiries collapse into one pending poll.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer        <= '0;
            r_poll_pending <= 1'b0;
        end else begin
            r_timer <= w_tmr_tc ? '0 : r_timer + 1'b1;
            if (w_tmr_tc)      r_poll_pending <= 1'b1;
            else if (w_btn_en) r_poll_pending <= 1'b0;
        end
    end

    // Two-sample debounce on completed reads, plus rising-edge press pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last    <= '0;
            r_held    <= '0;
            r_held_d  <= '0;
            r_pressed <= '0;
        end else begin
            if (r_state == S_SAMPLE) begin
                r_last <= i_lk_btn_state;
                r_held <= (i_lk_btn_state & r_last) | (r_held & (i_lk_btn_state | r_last));
            end
            r_held_d  <= r_held;
            r_pressed <= r_held & ~r_held_d;
        end
    end

    assign o_cmd_en          = w_cmd_en;
    assign o_batch_en        = w_batch_en;
    assign o_btn_en          = w_btn_en;
    assign o_data            = w_cmd_byte;
    assign o_batch_data_size = 5'd17;
    assign o_batch_data      = w_batch_en ? w_payload : r_batch_data;
    assign o_wait_counter    = 28'd1;
    assign o_btn_held        = r_held;
    assign o_btn_pressed     = r_pressed;
    assign o_busy            = (r_state != S_IDLE) | w_refresh | r_poll_pending;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_display_ctrl
// Brief    : Self-checking bench with a driver model, payload/debounce
//            reference model, vector table and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm1638_display_ctrl;

    localparam int c_period = 1000;  // poll interval with 1 MHz, 1 ms

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [31:0]  i_value;
    logic [7:0]   i_dp, i_leds;
    logic         i_update;
    logic         lk_idle = 1'b1;
    logic [7:0]   btn;
    logic         o_cmd_en, o_batch_en, o_btn_en;
    logic [7:0]   o_data;
    logic [4:0]   o_batch_data_size;
    logic [135:0] o_batch_data;
    logic [27:0]  o_wait_counter;
    logic [7:0]   o_btn_held, o_btn_pressed;
    logic         o_busy;

    tm1638_display_ctrl #(.CLOCK_FREQ_MHz(1), .POLL_MS(1), .BRIGHTNESS(3'd7)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_value(i_value), .i_dp(i_dp), .i_leds(i_leds),
        .i_update(i_update), .i_lk_idle(lk_idle), .i_lk_btn_state(btn),
        .o_cmd_en(o_cmd_en), .o_batch_en(o_batch_en), .o_btn_en(o_btn_en), .o_data(o_data),
        .o_batch_data_size(o_batch_data_size), .o_batch_data(o_batch_data),
        .o_wait_counter(o_wait_counter), .o_btn_held(o_btn_held),
        .o_btn_pressed(o_btn_pressed), .o_busy(o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    int total = 0, bad = 0;
    int n_req = 0, n_cmd = 0, n_batch = 0, n_btn = 0;
    int cyc = 0, last_req = -100;
    logic [7:0] last_cmd = 8'h00;
    int kind_q[$];
    logic [7:0] data_q[$];
    logic stall = 1'b0;
    logic [7:0] m_held = '0, m_prev = '0;
    int exp_press[8], got_press[8];

    localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference payload: list of 17 bytes, first-sent byte ends up at the top.
    function automatic logic [135:0] model_payload(input logic [31:0] v, input logic [7:0] dp,
                                                   input logic [7:0] leds);
        logic [7:0]   bytes [17];
        logic [135:0] r;
        logic [3:0]   nib;
        bytes[0] = 8'hC0;
        for (int d = 0; d < 8; d++) begin
            nib = 4'((v >> (28 - 4 * d)) & 32'hF);
            bytes[1 + 2 * d] = FONT[nib] | (dp[7 - d] ? 8'h80 : 8'h00);
            bytes[2 + 2 * d] = leds[7 - d] ? 8'h01 : 8'h00;
        end
        r = '0;
        for (int b = 0; b < 17; b++) r = (r << 8) | 136'(bytes[b]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor at negedge, driver model just after posedge.
    initial begin
        logic [7:0] s;
        logic       old;
        for (int k = 0; k < 8; k++) begin exp_press[k] = 0; got_press[k] = 0; end
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst_n !== 1'b1) begin
                m_held = '0; m_prev = '0; last_req = -100;
            end
            for (int k = 0; k < 8; k++) if (o_btn_pressed[k]) got_press[k]++;
            if (o_cmd_en || o_batch_en || o_btn_en) begin
                chk("issue_rule", {lk_idle, 2'($countones({o_cmd_en, o_batch_en, o_btn_en}))}, 3'b101);
                chk("issue_spacing", 136'(cyc - last_req >= 3), 136'd1);
                last_req = cyc;
                n_req++;
                if (o_cmd_en) begin
                    n_cmd++; last_cmd = o_data; kind_q.push_back(0); data_q.push_back(o_data);
                end
                if (o_batch_en) begin
                    n_batch++; kind_q.push_back(1); data_q.push_back(8'h00);
                    chk("batch_payload", o_batch_data, model_payload(i_value, i_dp, i_leds));
                    chk("batch_size", 136'(o_batch_data_size), 136'd17);
                end
                if (o_btn_en) begin
                    n_btn++; kind_q.push_back(2); data_q.push_back(8'h00);
                    s = btn;
                    for (int k = 0; k < 8; k++) begin
                        old = m_held[k];
                        if (s[k] && m_prev[k])        m_held[k] = 1'b1;
                        else if (!s[k] && !m_prev[k]) m_held[k] = 1'b0;
                        if (!old && m_held[k]) exp_press[k]++;
                    end
                    m_prev = s;
                end
            end
            @(posedge i_clk);
            #1;
            if (stall) lk_idle = 1'b0;
            else if (n_req != 0 && last_req == cyc && lk_idle) lk_idle = 1'b0;
            else if (!lk_idle && $urandom_range(2, 0) == 0) lk_idle = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic wait_quiet(input int max, input string nm);
        int c;
        c = 0;
        @(negedge i_clk);
        while (o_busy !== 1'b0 && c < max) begin @(negedge i_clk); c++; end
        if (o_busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL %s: o_busy still %b after %0d cycles, want 0", nm, o_busy, max);
        end
        tick(1);
    endtask

    task automatic check_init(input string nm);
        chk({nm, "_count"}, 136'(kind_q.size()), 136'd3);
        if (kind_q.size() >= 3) begin
            chk({nm, "_mode"}, {128'(kind_q[0]), data_q[0]}, {128'd0, 8'h40});
            chk({nm, "_batch"}, 136'(kind_q[1]), 136'd1);
            chk({nm, "_on"}, {128'(kind_q[2]), data_q[2]}, {128'd0, 8'h8F});
        end
    endtask

    task automatic poll_with(input logic [7:0] v, input string nm);
        int nb, c;
        btn = v;
        nb = n_btn; c = 0;
        while (n_btn == nb && c < 3 * c_period) begin @(negedge i_clk); c++; end
        if (n_btn == nb) begin
            total++; bad++;
            $display("FAIL %s: no o_btn_en in %0d cycles, want one", nm, c);
        end
        wait_quiet(100, nm);
        chk(nm, 136'(o_btn_held), 136'(m_held));
    endtask

    typedef struct {
        logic [31:0]  value;
        logic [7:0]   dp;
        logic [7:0]   leds;
        logic [135:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   nb, nc, nr, c, sum;
        logic [31:0] v;

        vecs[0] = '{32'h0123ABCD, 8'h80, 8'h01, 136'hC0_BF00_0600_5B00_4F00_7700_7C00_3900_5E01};
        vecs[1] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 136'hC0_F101_F101_F101_F101_F101_F101_F101_F101};
        vecs[2] = '{32'h89000000, 8'h01, 8'h80, 136'hC0_7F01_6F00_3F00_3F00_3F00_3F00_3F00_BF00};
        for (int i = 3; i < 7; i++) begin
            vecs[i].value = $urandom;
            vecs[i].dp    = 8'($urandom_range(255, 0));
            vecs[i].leds  = 8'($urandom_range(255, 0));
            vecs[i].exp   = model_payload(vecs[i].value, vecs[i].dp, vecs[i].leds);
        end

        i_rst_n = 1'b0; i_value = '0; i_dp = '0; i_leds = '0; i_update = 1'b0; btn = '0;
        tick(3);
        chk("rst_enables", 136'({o_cmd_en, o_batch_en, o_btn_en}), 136'd0);
        chk("rst_data", 136'(o_data), 136'd0);
        chk("rst_batch_data", o_batch_data, 136'd0);
        chk("rst_size", 136'(o_batch_data_size), 136'd17);
        chk("rst_btn", 136'({o_btn_held, o_btn_pressed}), 136'd0);
        chk("rst_busy", 136'(o_busy), 136'd1);
        chk("wait_counter", 136'(o_wait_counter), 136'd1);

        kind_q.delete(); data_q.delete();
        i_rst_n = 1'b1;
        wait_quiet(200, "init_done");
        check_init("init");
        chk("init_snapshot", o_batch_data, model_payload(32'd0, 8'd0, 8'd0));

        for (int i = 0; i < 7; i++) begin
            nb = n_batch; nc = n_cmd;
            i_value = vecs[i].value; i_dp = vecs[i].dp; i_leds = vecs[i].leds;
            wait_quiet(200, "vec_quiet");
            chk("vec_batches", 136'(n_batch - nb), 136'd1);
            chk("vec_mode_cmd", {128'(n_cmd - nc), last_cmd}, {128'd1, 8'h40});
            chk("vec_payload", o_batch_data, vecs[i].exp);
            if (i == 0) begin
                nb = n_batch;
                tick(150);
                chk("stable_no_batch", 136'(n_batch - nb), 136'd0);
            end
        end

        nb = n_batch;
        i_update = 1'b1; tick(1); i_update = 1'b0;
        wait_quiet(200, "update_quiet");
        chk("update_one_batch", 136'(n_batch - nb), 136'd1);
        chk("update_payload", o_batch_data, vecs[6].exp);

        nb = n_batch; nc = n_cmd;
        i_value = 32'h11112222;
        c = 0;
        @(negedge i_clk);
        while (!o_batch_en && c < 200) begin @(negedge i_clk); c++; end
        chk("inflight_seen_batch", 136'(o_batch_en), 136'd1);
        tick(1);
        i_value = 32'h3333CAFE;
        wait_quiet(300, "inflight_quiet");
        chk("inflight_batches", 136'(n_batch - nb), 136'd2);
        chk("inflight_cmds", 136'(n_cmd - nc), 136'd2);
        chk("inflight_payload", o_batch_data, model_payload(32'h3333CAFE, i_dp, i_leds));

        poll_with(8'h04, "btn_first_poll");
        chk("btn_not_yet", 136'(o_btn_held), 136'd0);
        poll_with(8'h04, "btn_second_poll");
        chk("btn_held_04", 136'(o_btn_held), 136'h04);
        tick(3);
        chk("btn_one_pulse", 136'(got_press[2]), 136'd1);
        poll_with(8'h10, "btn_glitch");
        chk("glitch_held", 136'(o_btn_held), 136'h04);
        poll_with(8'h04, "btn_after_glitch");
        tick(3);
        chk("glitch_no_pulse", 136'(got_press[4] + got_press[2]), 136'd1);
        for (int i = 0; i < 6; i++) poll_with(8'($urandom_range(255, 0)), "btn_random");

        poll_with(btn, "stall_align");
        stall = 1'b1;
        tick(2);
        nr = n_req;
        tick(5 * c_period);
        chk("stall_no_request", 136'(n_req - nr), 136'd0);
        chk("stall_busy", 136'(o_busy), 136'd1);
        nb = n_btn;
        stall = 1'b0;
        wait_quiet(200, "stall_release");
        chk("stall_one_poll", 136'(n_btn - nb), 136'd1);

        i_value = 32'hDEADBEEF;
        c = 0;
        @(negedge i_clk);
        while (!o_batch_en && c < 300) begin @(negedge i_clk); c++; end
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_mid_enables", 136'({o_cmd_en, o_batch_en, o_btn_en}), 136'd0);
        chk("rst_mid_state", {o_batch_data, 6'd0, o_busy, 1'b0}, {136'd0, 6'd0, 1'b1, 1'b0});
        chk("rst_mid_held", 136'(o_btn_held), 136'd0);
        tick(3);
        kind_q.delete(); data_q.delete();
        i_rst_n = 1'b1;
        wait_quiet(300, "reinit_done");
        check_init("reinit");
        chk("reinit_payload", o_batch_data, model_payload(i_value, i_dp, i_leds));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3, 0))
                0: i_value = $urandom;
                1: begin i_dp = 8'($urandom_range(255, 0)); i_leds = 8'($urandom_range(255, 0)); end
                2: begin i_update = 1'b1; tick(1); i_update = 1'b0; end
                default: begin v = $urandom; i_value = {i_value[31:16], v[15:0]}; end
            endcase
            tick($urandom_range(12, 1));
            if (i % 8 == 7) begin
                wait_quiet(400, "rand_quiet");
                chk("rand_payload", o_batch_data, model_payload(i_value, i_dp, i_leds));
            end
        end
        wait_quiet(400, "final_quiet");
        chk("final_payload", o_batch_data, model_payload(i_value, i_dp, i_leds));
        tick(3);
        sum = 0;
        for (int k = 0; k < 8; k++) sum += (got_press[k] == exp_press[k]) ? 0 : 1;
        chk("press_counts", 136'(sum), 136'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
